// File: rtl/game_sequencer_if.sv
// Bundles the game-controller inputs from the player/car sprite logic and the
// status and strobe outputs sent to the renderer and the sprite modules.
interface game_sequencer_if #(
  parameter int NUM_LANES = 6
);
  logic                 i_start;
  logic                 i_collision;
  logic                 i_at_goal;
  logic [NUM_LANES-1:0] o_lane_tick;
  logic                 o_player_reset;
  logic [6:0]           o_level;
  logic [1:0]           o_state;
  logic                 o_freeze;

  modport master (
    output i_start, i_collision, i_at_goal,
    input  o_lane_tick, o_player_reset, o_level, o_state, o_freeze
  );

  modport slave (
    input  i_start, i_collision, i_at_goal,
    output o_lane_tick, o_player_reset, o_level, o_state, o_freeze
  );
endinterface

// File: rtl/game_sequencer.sv
// Road-crossing game controller: round state machine, level counter (0..99),
// and per-lane car move strobes whose period shrinks as the level rises.

// One lane's move pacing. The counter value held in cnt_q belongs to the
// current cycle. The strobe flop is loaded from the next-cycle count, so the
// registered tick lines up with the cycle in which the count reaches Pk-1.
module game_seq_lane #(
  parameter int LANE      = 0,
  parameter int LANE_SKEW = 1250000
) (
  input  logic        i_Clk,
  input  logic        i_reset,
  input  logic        i_enter,      // next cycle is the first PLAY cycle
  input  logic        i_run,        // this cycle and the next are both PLAY
  input  logic        i_play_next,  // next cycle is PLAY
  input  logic [31:0] i_base_q,     // level-scaled period for the current level
  input  logic [31:0] i_base_d,     // level-scaled period for the next level
  output logic        o_tick
);
  localparam logic [31:0] SKEW = 32'(LANE * LANE_SKEW);

  logic [25:0] cnt_q, cnt_d;
  logic        tick_q, tick_d;
  logic [31:0] per_q, per_d;

  assign per_q = i_base_q + SKEW;
  assign per_d = i_base_d + SKEW;

  // Count up while playing, wrap on the period, hold while frozen.
  // Using >= also handles a period that shrinks while the count is in flight.
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (i_enter) begin
      cnt_d = '0;
    end else if (i_run) begin
      cnt_d = ({6'd0, cnt_q} >= per_q - 32'd1) ? '0 : cnt_q + 26'd1;
    end
    tick_d = i_play_next && ({6'd0, cnt_d} >= per_d - 32'd1);
  end

  // Count and strobe registers.
  always_ff @(posedge i_Clk or posedge i_reset) begin
    if (i_reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign o_tick = tick_q;
endmodule

module game_sequencer #(
  parameter int NUM_LANES   = 6,
  parameter int BASE_PERIOD = 25000000,
  parameter int SPEED_STEP  = 200000,
  parameter int MIN_PERIOD  = 2500000,
  parameter int LANE_SKEW   = 1250000,
  parameter int HIT_HOLD    = 12500000,
  parameter int WIN_HOLD    = 6250000
) (
  input logic              i_Clk,
  input logic              i_reset,
  game_sequencer_if.slave  sif
);
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_PLAY = 2'b01,
    S_HIT  = 2'b10,
    S_WIN  = 2'b11
  } state_t;

  state_t      state_q, state_d;
  logic [6:0]  level_q, level_d;
  logic [25:0] hold_q, hold_d;
  logic        start_q, start_d;
  logic        player_reset_q, player_reset_d;
  logic        freeze_q, freeze_d;
  logic [NUM_LANES-1:0] lane_tick;
  logic [31:0] base_q, base_d;

  // max(MIN_PERIOD, BASE_PERIOD - lvl*SPEED_STEP); a negative difference
  // collapses to the floor instead of wrapping.
  function automatic logic [31:0] scaled_period(input logic [6:0] lvl);
    logic [31:0] prod;
    logic [31:0] p;
    prod = 32'(lvl) * 32'(SPEED_STEP);
    if (prod >= 32'(BASE_PERIOD)) p = 32'(MIN_PERIOD);
    else                          p = 32'(BASE_PERIOD) - prod;
    if (p < 32'(MIN_PERIOD)) p = 32'(MIN_PERIOD);
    return p;
  endfunction

  assign base_q = scaled_period(level_q);
  assign base_d = scaled_period(level_d);

  // Round state machine: start edge, collision/goal resolution, freeze timers.
  always_comb begin
    state_d        = state_q;
    level_d        = level_q;
    hold_d         = hold_q;
    start_d        = sif.i_start;
    player_reset_d = 1'b0;
    freeze_d       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (sif.i_start && !start_q) state_d = S_PLAY;
      end
      S_PLAY: begin
        // Collision wins over a simultaneous goal.
        if (sif.i_collision) begin
          state_d = S_HIT;
          level_d = 7'd0;
          hold_d  = '0;
        end else if (sif.i_at_goal) begin
          state_d = S_WIN;
          level_d = (level_q >= 7'd99) ? 7'd0 : level_q + 7'd1;
          hold_d  = '0;
        end
      end
      S_HIT: begin
        if ({6'd0, hold_q} >= 32'(HIT_HOLD - 1)) state_d = S_PLAY;
        else                                      hold_d  = hold_q + 26'd1;
      end
      S_WIN: begin
        if ({6'd0, hold_q} >= 32'(WIN_HOLD - 1)) state_d = S_PLAY;
        else                                      hold_d  = hold_q + 26'd1;
      end
      default: state_d = S_IDLE;
    endcase
    // Returning to PLAY after a win leaves the player where the goal logic put it.
    player_reset_d = ((state_q == S_IDLE || state_q == S_HIT) && state_d == S_PLAY) ||
                     (state_q == S_PLAY && state_d == S_WIN);
    freeze_d       = (state_d == S_HIT) || (state_d == S_WIN);
  end

  // Controller registers; every output comes straight from one of these.
  always_ff @(posedge i_Clk or posedge i_reset) begin
    if (i_reset) begin
      state_q        <= S_IDLE;
      level_q        <= 7'd0;
      hold_q         <= '0;
      start_q        <= 1'b0;
      player_reset_q <= 1'b0;
      freeze_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      level_q        <= level_d;
      hold_q         <= hold_d;
      start_q        <= start_d;
      player_reset_q <= player_reset_d;
      freeze_q       <= freeze_d;
    end
  end

  logic enter_play, run_play, play_next;
  assign enter_play = (state_d == S_PLAY) && (state_q != S_PLAY);
  assign run_play   = (state_d == S_PLAY) && (state_q == S_PLAY);
  assign play_next  = (state_d == S_PLAY);

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    game_seq_lane #(
      .LANE      (k),
      .LANE_SKEW (LANE_SKEW)
    ) u_lane (
      .i_Clk       (i_Clk),
      .i_reset     (i_reset),
      .i_enter     (enter_play),
      .i_run       (run_play),
      .i_play_next (play_next),
      .i_base_q    (base_q),
      .i_base_d    (base_d),
      .o_tick      (lane_tick[k])
    );
  end

  assign sif.o_lane_tick    = lane_tick;
  assign sif.o_player_reset = player_reset_q;
  assign sif.o_level        = level_q;
  assign sif.o_state        = state_q;
  assign sif.o_freeze       = freeze_q;
endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer with small periods
// (BASE=10 STEP=2 MIN=4 SKEW=1 LANES=6 HIT=5 WIN=3).
module tb_game_sequencer;
  localparam int LANES = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vecs = 0;
  int   errs = 0;

  game_sequencer_if #(.NUM_LANES(LANES)) gif ();

  game_sequencer #(
    .NUM_LANES(LANES), .BASE_PERIOD(10), .SPEED_STEP(2), .MIN_PERIOD(4),
    .LANE_SKEW(1), .HIT_HOLD(5), .WIN_HOLD(3)
  ) dut (
    .i_Clk   (clk),
    .i_reset (rst),
    .sif     (gif)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled and inputs driven 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected strobe vector for PLAY cycle c when lane k period is p0+k.
  function automatic logic [LANES-1:0] exp_ticks(input int c, input int p0);
    logic [LANES-1:0] v;
    for (int k = 0; k < LANES; k++) v[k] = ((c % (p0 + k)) == 0);
    return v;
  endfunction

  // From the first PLAY cycle, check every strobe for n cycles.
  task automatic check_ticks(input string name, input int n, input int p0);
    logic [LANES-1:0] e;
    for (int c = 1; c <= n; c++) begin
      if (c > 1) tick();
      e = exp_ticks(c, p0);
      vecs++;
      if (gif.o_lane_tick !== e) begin
        errs++;
        $display("FAIL %s cycle %0d: ticks=%b expected=%b", name, c, gif.o_lane_tick, e);
      end
    end
  endtask

  // One goal from PLAY cycle 1 back to PLAY cycle 1.
  task automatic win_once();
    gif.i_at_goal = 1'b1;
    tick();
    gif.i_at_goal = 1'b0;
    tick(); tick(); tick();
  endtask

  task automatic test_reset();
    gif.i_start = 1'b0; gif.i_collision = 1'b0; gif.i_at_goal = 1'b0;
    rst = 1'b1;
    tick(); tick();
    vecs++; if (gif.o_state !== 2'b00) begin errs++; $display("FAIL reset_state: got %b want 00", gif.o_state); end
    vecs++; if (gif.o_level !== 7'd0) begin errs++; $display("FAIL reset_level: got %0d want 0", gif.o_level); end
    vecs++; if (gif.o_lane_tick !== '0) begin errs++; $display("FAIL reset_ticks: got %b want 0", gif.o_lane_tick); end
    vecs++; if (gif.o_player_reset !== 1'b0) begin errs++; $display("FAIL reset_preset: got %b want 0", gif.o_player_reset); end
    vecs++; if (gif.o_freeze !== 1'b0) begin errs++; $display("FAIL reset_freeze: got %b want 0", gif.o_freeze); end
    rst = 1'b0;
    tick(); tick();
    vecs++; if (gif.o_state !== 2'b00) begin errs++; $display("FAIL idle_no_start: got %b want 00", gif.o_state); end
  endtask

  task automatic test_start_ticks();
    gif.i_start = 1'b1;
    tick();
    gif.i_start = 1'b0;
    vecs++; if (gif.o_state !== 2'b01) begin errs++; $display("FAIL start_state: got %b want 01", gif.o_state); end
    vecs++; if (gif.o_player_reset !== 1'b1) begin errs++; $display("FAIL start_preset: got %b want 1", gif.o_player_reset); end
    check_ticks("lvl0_ticks", 30, 10);
    vecs++; if (gif.o_player_reset !== 1'b0) begin errs++; $display("FAIL start_preset_once: got %b want 0", gif.o_player_reset); end
  endtask

  task automatic test_win();
    int pulses;
    gif.i_at_goal = 1'b1;
    tick();
    vecs++; if (gif.o_state !== 2'b11) begin errs++; $display("FAIL win_state: got %b want 11", gif.o_state); end
    vecs++; if (gif.o_level !== 7'd1) begin errs++; $display("FAIL win_level: got %0d want 1", gif.o_level); end
    vecs++; if (gif.o_freeze !== 1'b1) begin errs++; $display("FAIL win_freeze: got %b want 1", gif.o_freeze); end
    pulses = int'(gif.o_player_reset);
    // Goal stays high and a collision appears; both must be ignored in WIN.
    gif.i_collision = 1'b1;
    tick(); pulses += int'(gif.o_player_reset);
    tick(); pulses += int'(gif.o_player_reset);
    vecs++; if (gif.o_state !== 2'b11 || gif.o_lane_tick !== '0) begin
      errs++; $display("FAIL win_hold: state=%b ticks=%b want 11/0", gif.o_state, gif.o_lane_tick);
    end
    gif.i_at_goal = 1'b0; gif.i_collision = 1'b0;
    tick(); pulses += int'(gif.o_player_reset);
    vecs++; if (pulses != 1) begin errs++; $display("FAIL win_pulses: got %0d want 1", pulses); end
    vecs++; if (gif.o_state !== 2'b01 || gif.o_freeze !== 1'b0) begin
      errs++; $display("FAIL win_return: state=%b freeze=%b want 01/0", gif.o_state, gif.o_freeze);
    end
    vecs++; if (gif.o_level !== 7'd1) begin errs++; $display("FAIL win_level_once: got %0d want 1", gif.o_level); end
    check_ticks("lvl1_ticks", 16, 8);
  endtask

  task automatic test_level_scale();
    win_once(); win_once(); win_once();
    vecs++; if (gif.o_level !== 7'd4) begin errs++; $display("FAIL level4: got %0d want 4", gif.o_level); end
    check_ticks("lvl4_ticks", 12, 4);
    tick();
    for (int i = 0; i < 95; i++) win_once();
    vecs++; if (gif.o_level !== 7'd99) begin errs++; $display("FAIL level99: got %0d want 99", gif.o_level); end
    check_ticks("lvl99_ticks", 8, 4);
    tick();
    win_once();
    vecs++; if (gif.o_level !== 7'd0) begin errs++; $display("FAIL level_wrap: got %0d want 0", gif.o_level); end
  endtask

  task automatic test_hit();
    for (int i = 0; i < 7; i++) win_once();
    vecs++; if (gif.o_level !== 7'd7) begin errs++; $display("FAIL level7: got %0d want 7", gif.o_level); end
    gif.i_collision = 1'b1; gif.i_at_goal = 1'b1;
    tick();
    gif.i_collision = 1'b0; gif.i_at_goal = 1'b0;
    vecs++; if (gif.o_state !== 2'b10) begin errs++; $display("FAIL hit_priority: got %b want 10", gif.o_state); end
    vecs++; if (gif.o_level !== 7'd0) begin errs++; $display("FAIL hit_level: got %0d want 0", gif.o_level); end
    vecs++; if (gif.o_player_reset !== 1'b0) begin errs++; $display("FAIL hit_preset: got %b want 0", gif.o_player_reset); end
    for (int c = 2; c <= 5; c++) begin
      tick();
      vecs++;
      if (gif.o_state !== 2'b10 || gif.o_lane_tick !== '0 || gif.o_freeze !== 1'b1) begin
        errs++; $display("FAIL hit_frozen c%0d: state=%b ticks=%b freeze=%b", c, gif.o_state, gif.o_lane_tick, gif.o_freeze);
      end
    end
    tick();
    vecs++; if (gif.o_state !== 2'b01 || gif.o_player_reset !== 1'b1 || gif.o_freeze !== 1'b0) begin
      errs++; $display("FAIL hit_return: state=%b preset=%b freeze=%b want 01/1/0", gif.o_state, gif.o_player_reset, gif.o_freeze);
    end
    check_ticks("hit_restart_ticks", 10, 10);
  endtask

  task automatic test_reset_mid_hit();
    tick();
    gif.i_collision = 1'b1;
    tick();
    gif.i_collision = 1'b0;
    tick();
    vecs++; if (gif.o_state !== 2'b10 || gif.o_freeze !== 1'b1) begin
      errs++; $display("FAIL hit2_state: state=%b freeze=%b want 10/1", gif.o_state, gif.o_freeze);
    end
    #1 rst = 1'b1;
    #1;
    vecs++;
    if (gif.o_state !== 2'b00 || gif.o_level !== 7'd0 || gif.o_lane_tick !== '0 ||
        gif.o_player_reset !== 1'b0 || gif.o_freeze !== 1'b0) begin
      errs++; $display("FAIL async_reset: state=%b level=%0d ticks=%b preset=%b freeze=%b",
                       gif.o_state, gif.o_level, gif.o_lane_tick, gif.o_player_reset, gif.o_freeze);
    end
    tick();
    rst = 1'b0;
    tick();
    gif.i_start = 1'b1;
    tick();
    gif.i_start = 1'b0;
    vecs++; if (gif.o_state !== 2'b01 || gif.o_player_reset !== 1'b1) begin
      errs++; $display("FAIL restart: state=%b preset=%b want 01/1", gif.o_state, gif.o_player_reset);
    end
  endtask

  task automatic test_start_hold();
    int pulses;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    pulses = 0;
    gif.i_start = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      pulses += int'(gif.o_player_reset);
    end
    vecs++; if (pulses != 1) begin errs++; $display("FAIL start_hold_pulses: got %0d want 1", pulses); end
    vecs++; if (gif.o_state !== 2'b01) begin errs++; $display("FAIL start_hold_state: got %b want 01", gif.o_state); end
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      gif.i_start = i[0];
      tick();
      pulses += int'(gif.o_player_reset);
    end
    gif.i_start = 1'b0;
    vecs++; if (pulses != 0 || gif.o_state !== 2'b01) begin
      errs++; $display("FAIL start_toggle: pulses=%0d state=%b want 0/01", pulses, gif.o_state);
    end
  endtask

  initial begin
    gif.i_start = 1'b0; gif.i_collision = 1'b0; gif.i_at_goal = 1'b0;
    test_reset();
    test_start_ticks();
    test_win();
    test_level_scale();
    test_hit();
    test_reset_mid_hit();
    test_start_hold();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
